result_select_mux: RTL and testbench
====================================

RESULT_SELECT_MUX -- requirements
Module: result_select_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel, SHALL be >= 1.
REQ-002 Parameter NUM_IN, default 16: input channel count, SHALL be 2..64.
REQ-003 Derived localparam SEL_W = $clog2(NUM_IN), SHALL NOT be overridable.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel select, used in mode 0.
REQ-008 mode  input  1  0 = external select, 1 = auto round-robin.
REQ-009 in_valid  input  1  upstream offers a transfer.
REQ-010 in_ready  output  1  block accepts a transfer this cycle.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_sel  output  SEL_W  channel index that produced out_data.
REQ-013 out_valid  output  1  out_data/out_sel hold a result.
REQ-014 out_ready  input  1  downstream consumes result.
REQ-015 err_clr  input  1  clears sel_err.
REQ-016 sel_err  output  1  sticky out-of-range select flag.

Function
REQ-017 Accept occurs when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-018 On accept, out_data, out_sel load the chosen channel at the same edge; latency exactly 1 cycle from accept to out_valid=1.
REQ-019 Effective index: mode 0 -> sel; mode 1 -> internal pointer rr_ptr; mode sampled at accept edge.
REQ-020 out_valid SHALL set on accept, clear on out_ready without accept, stay 1 on simultaneous consume and accept (back-to-back, one result per cycle).
REQ-021 With out_valid=1 and out_ready=0, out_data/out_sel SHALL hold stable.
REQ-022 rr_ptr SHALL increment only on accept in mode 1; wraps NUM_IN-1 -> 0; held unchanged in mode 0.
REQ-023 Effective index >= NUM_IN (non-power-of-2 NUM_IN only): transfer still accepted, out_data = 0, out_sel = index as given, sel_err set next edge.
REQ-024 sel_err SHALL remain 1 until err_clr=1 at a clock edge; simultaneous set and err_clr -> set wins (sel_err=1).
REQ-025 No combinational path from in_data or sel to out_data.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, out_sel=0, rr_ptr=0, sel_err=0; in_ready=1 follows from out_valid=0.
REQ-027 Reset assertion mid-transfer SHALL discard the held result; no transfer is accepted in the cycle rst_n deasserts if it is low at that edge.

Structure
REQ-028 Defaults RSM_WIDTH=32, RSM_NUM_IN=16 and the mode encoding constants SHALL live in shared package alu_pkg.
REQ-029 The round-robin pointer (increment, wrap, hold) SHALL be sub-module rsm_rr_ptr with ports clk, rst_n, adv, ptr.
REQ-030 Target size 120-400 RTL lines including the sub-module.

Verification
REQ-031 Mode 0, NUM_IN=16, in_k=32'hA000_0000+k, sel=5, out_ready=1 -> next cycle out_data=32'hA000_0005, out_sel=5, out_valid=1.
REQ-032 Mode 1, in_valid held 18 cycles, out_ready=1 -> out_sel sequence 0..15,0,1; one result per cycle.
REQ-033 out_ready=0 after one accept -> in_ready=0, out_data stable 4 cycles; out_ready=1 -> consumed, next accept lands same cycle.
REQ-034 NUM_IN=12, sel=13 -> out_data=0, out_sel=13, sel_err=1; err_clr with another bad sel same cycle -> sel_err stays 1; err_clr alone -> 0.
REQ-035 rst_n low mid-stream in mode 1 with rr_ptr=7 -> out_valid=0 immediately (async), after release first mode-1 accept yields out_sel=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared defaults and mode encoding for the result select mux
package alu_pkg;

    localparam int RSM_WIDTH  = 32;
    localparam int RSM_NUM_IN = 16;

    typedef enum logic {
        RSM_MODE_SEL = 1'b0,
        RSM_MODE_RR  = 1'b1
    } rsm_mode_e;

endpackage

// File: rtl/rsm_rr_ptr.sv
// rtl/rsm_rr_ptr.sv - round-robin channel pointer, advances on adv and wraps at NUM_IN-1
module rsm_rr_ptr #(
    parameter  int NUM_IN = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [SEL_W-1:0] ptr
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/result_select_mux.sv
// rtl/result_select_mux.sv - registered N:1 channel select with external or round-robin index
module result_select_mux
    import alu_pkg::*;
#(
    parameter  int WIDTH  = RSM_WIDTH,
    parameter  int NUM_IN = RSM_NUM_IN,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    sel_err
);

    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

    logic             w_accept;
    logic             w_rr_mode;
    logic             w_oor;
    logic [SEL_W-1:0] w_rr_ptr;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_pick;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;
    logic             r_err;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_rr_mode = (rsm_mode_e'(mode) == RSM_MODE_RR);
    assign w_idx     = w_rr_mode ? w_rr_ptr : sel;
    assign w_oor     = ({1'b0, w_idx} >= NUM_IN_EXT);

    // An out-of-range index matches no channel, so the picked word falls back to zero.
    always_comb begin
        w_pick = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_pick = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    rsm_rr_ptr #(
        .NUM_IN (NUM_IN)
    ) u_rr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (w_accept && w_rr_mode),
        .ptr   (w_rr_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_pick;
                r_sel   <= w_idx;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // A fresh bad select outranks a clear in the same cycle.
            if (w_accept && w_oor) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign sel_err   = r_err;

endmodule

// File: tb/tb_result_select_mux.sv
// tb/tb_result_select_mux.sv - self-checking bench for result_select_mux (NUM_IN 16 and 12)
module tb_result_select_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] dat  [2];
    logic [3:0]   sl   [2];
    logic         md   [2];
    logic         iv   [2];
    logic         ordy [2];
    logic         eclr [2];
    logic         rdy  [2];
    logic [31:0]  od   [2];
    logic [3:0]   os   [2];
    logic         ov   [2];
    logic         oe   [2];

    logic [16*32-1:0] dat_a;
    logic [12*32-1:0] dat_b;
    assign dat_a = dat[0];
    assign dat_b = dat[1][12*32-1:0];

    int          nch     [2] = '{16, 12};
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    int          m_sel   [2];
    int          m_ptr   [2];
    logic        m_err   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    result_select_mux #(.WIDTH(32), .NUM_IN(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(dat_a), .sel(sl[0]), .mode(md[0]),
        .in_valid(iv[0]), .in_ready(rdy[0]), .out_data(od[0]), .out_sel(os[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .err_clr(eclr[0]), .sel_err(oe[0])
    );

    result_select_mux #(.WIDTH(32), .NUM_IN(12)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(dat_b), .sel(sl[1]), .mode(md[1]),
        .in_valid(iv[1]), .in_ready(rdy[1]), .out_data(od[1]), .out_sel(os[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .err_clr(eclr[1]), .sel_err(oe[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_pick(input logic [511:0] d, input int n, input int idx);
        logic [511:0] t;
        if (idx >= n) return 32'h0;
        t = d >> (idx * 32);
        return t[31:0];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_data[d] = '0; m_sel[d] = 0; m_ptr[d] = 0; m_err[d] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; eclr[d] = 1'b0; md[d] = 1'b0; sl[d] = '0;
        end
    endtask

    // One clock: check ready against the model, advance the model, then check registered outputs.
    task automatic cycle();
        logic acc;
        int   idx;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready[%0d]", d), 32'(rdy[d]), 32'(!m_valid[d] || ordy[d]));
            acc = iv[d] && (!m_valid[d] || ordy[d]);
            idx = md[d] ? m_ptr[d] : int'(sl[d]);
            if (acc) begin
                m_valid[d] = 1'b1;
                m_data[d]  = ref_pick(dat[d], nch[d], idx);
                m_sel[d]   = idx;
            end else if (ordy[d]) begin
                m_valid[d] = 1'b0;
            end
            if (acc && idx >= nch[d]) m_err[d] = 1'b1;
            else if (eclr[d])         m_err[d] = 1'b0;
            if (acc && md[d])         m_ptr[d] = (m_ptr[d] + 1) % nch[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_valid[d]));
            if (m_valid[d]) begin
                chk($sformatf("out_data[%0d]", d), od[d], m_data[d]);
                chk($sformatf("out_sel[%0d]", d), 32'(os[d]), 32'(m_sel[d]));
            end
            chk($sformatf("sel_err[%0d]", d), 32'(oe[d]), 32'(m_err[d]));
        end
    endtask

    // Asynchronous reset mid-cycle, held across one edge with transfers offered.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid[%0d]", d), 32'(ov[d]), 32'h0);
            chk($sformatf("rst_data[%0d]", d), od[d], 32'h0);
            chk($sformatf("rst_sel[%0d]", d), 32'(os[d]), 32'h0);
            chk($sformatf("rst_err[%0d]", d), 32'(oe[d]), 32'h0);
            chk($sformatf("rst_ready[%0d]", d), 32'(rdy[d]), 32'h1);
            iv[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("rst_hold_valid[%0d]", d), 32'(ov[d]), 32'h0);
        #2;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        dat[0] = '0;
        dat[1] = '0;
        for (int k = 0; k < 16; k++) dat[0][k*32 +: 32] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 12; k++) dat[1][k*32 +: 32] = 32'hB000_0000 + 32'(k);
        #3;
        do_reset();

        // External select of channel 5
        iv[0] = 1'b1; sl[0] = 4'd5;
        cycle();
        chk("sel5_data", od[0], 32'hA000_0005);
        chk("sel5_sel", 32'(os[0]), 32'd5);
        iv[0] = 1'b0;
        cycle();

        // Round-robin streaming, 18 back-to-back results
        iv[0] = 1'b1; md[0] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cycle();
            chk("rr_seq", 32'(os[0]), 32'(i % 16));
        end
        iv[0] = 1'b0; md[0] = 1'b0;
        cycle();

        // Backpressure: one accept, stall 4 cycles with new data offered, then release
        iv[0] = 1'b1; sl[0] = 4'd9; ordy[0] = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            sl[0] = 4'(i);
            for (int k = 0; k < 16; k++) dat[0][k*32 +: 32] = $urandom;
            cycle();
            chk("stall_data", od[0], 32'hA000_0009);
            chk("stall_ready", 32'(rdy[0]), 32'h0);
        end
        ordy[0] = 1'b1; sl[0] = 4'd2;
        cycle();
        iv[0] = 1'b0;
        cycle();

        // Out-of-range select on the 12-channel instance
        iv[1] = 1'b1; sl[1] = 4'd13;
        cycle();
        chk("oor_data", od[1], 32'h0);
        chk("oor_sel", 32'(os[1]), 32'd13);
        chk("oor_err", 32'(oe[1]), 32'h1);
        sl[1] = 4'd14; eclr[1] = 1'b1;
        cycle();
        chk("oor_set_wins", 32'(oe[1]), 32'h1);
        iv[1] = 1'b0;
        cycle();
        chk("oor_cleared", 32'(oe[1]), 32'h0);
        eclr[1] = 1'b0;

        // Round-robin up to pointer 7, then reset mid-stream
        iv[0] = 1'b1; md[0] = 1'b1;
        for (int i = 0; i < 16 && m_ptr[0] != 7; i++) cycle();
        chk("rr_at7", 32'(m_ptr[0]), 32'd7);
        do_reset();
        iv[0] = 1'b1; md[0] = 1'b1;
        cycle();
        chk("rr_after_reset", 32'(os[0]), 32'h0);
        idle_inputs();
        cycle();

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d]   = 1'($urandom_range(0, 3) != 0);
                md[d]   = 1'($urandom_range(0, 1));
                sl[d]   = 4'($urandom_range(0, 15));
                ordy[d] = 1'($urandom_range(0, 3) != 0);
                eclr[d] = 1'($urandom_range(0, 7) == 0);
                for (int k = 0; k < nch[d]; k++) dat[d][k*32 +: 32] = $urandom;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
